ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
Parametrised ball-motion engine for the breakout datapath. On each frame tick it advances the ball by programmable X/Y steps and resolves collisions in one cycle: screen walls, paddle and brick-hit flags. It also detects a missed ball. It sits between the frame-timing generator and the VGA object renderer, and drives the ball position and direction to the draw logic and the brick checker.

Parameters:
W, 10, coordinate width in bits
STEP_W, 4, width of the step inputs
X_MAX, 639, rightmost pixel column
Y_MAX, 479, bottom pixel row
BALL_SIZE, 4, ball edge length in pixels (square)
PADDLE_Y, 460, top row of the paddle
PADDLE_W, 32, paddle width in pixels
X_INIT, 320, launch X position
Y_INIT, 240, launch Y position
DIR_INIT, 2'b10, launch direction

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
launch  in  1  start the ball, or restart it after a loss
frame_tick  in  1  one-cycle motion strobe
xstep  in  STEP_W  pixels per tick in X
ystep  in  STEP_W  pixels per tick in Y
paddle_x  in  W  left column of the paddle
brick_hit_x  in  1  brick side collision; toggle X direction
brick_hit_y  in  1  brick top/bottom collision; toggle Y direction
ball_x  out  W  ball left column
ball_y  out  W  ball top row
dir  out  2  bit0=1: X decreasing; bit1=1: Y decreasing
moving  out  1  high while in MOVE
ball_lost  out  1  one-cycle pulse when the ball is missed
bounce_count  out  8  wall and paddle bounces since launch; saturates at 255

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on resetn.
- Reset values: state=IDLE, ball_x=X_INIT, ball_y=Y_INIT, dir=DIR_INIT, moving=0, ball_lost=0, bounce_count=0. Reset may be asserted mid-MOVE and takes effect immediately.
- FSM states: IDLE, MOVE, LOST.
  - IDLE: launch -> MOVE; bounce_count cleared.
  - MOVE: on frame_tick, update position/direction (rules below).
  - LOST: launch -> MOVE; ball_x/ball_y/dir reloaded to X_INIT/Y_INIT/DIR_INIT; bounce_count cleared.
- frame_tick is ignored in IDLE and LOST. Outputs are frozen outside MOVE ticks.
- Latency: a tick sampled on edge N gives updated ball_x/ball_y/dir/bounce_count after edge N.
- Tick evaluation order:
  1. Effective direction e = dir XOR {brick_hit_y, brick_hit_x}. Brick toggles are not counted as bounces.
  2. Compute candidates nx and ny in W+1 bits: add the step if the e bit is 0, subtract it if the e bit is 1.
- X rules:
  - e0=0 and nx+BALL_SIZE-1 > X_MAX: x = X_MAX-BALL_SIZE+1, dir0 = 1, bounce.
  - e0=1 and x < xstep: x = 0, dir0 = 0, bounce.
  - Otherwise x = nx, dir0 = e0.
- Y rules (paddle overlap is evaluated with the new x):
  - e1=1 and y < ystep: y = 0, dir1 = 0, bounce.
  - e1=0 and ny+BALL_SIZE-1 >= PADDLE_Y:
    - Overlap (x+BALL_SIZE-1 >= paddle_x and x <= paddle_x+PADDLE_W-1): y = PADDLE_Y-BALL_SIZE, dir1 = 1, bounce.
    - No overlap: y = Y_MAX-BALL_SIZE+1, go to LOST, pulse ball_lost for one cycle, moving = 0.
  - Otherwise y = ny, dir1 = e1.
- Bounce counting: an X and a Y bounce in the same tick add 2; saturate at 255.
- Zero step: xstep=0 means no X motion and no X wall bounce; same for Y.
- Brick plus wall in the same tick: the brick toggle is applied first, then wall checks use the toggled direction.
- launch asserted in MOVE has no effect.

Test Plan:
1. Reset and idle: resetn low mid-MOVE -> ball_x=320, ball_y=240, dir=2'b10, moving=0 immediately. frame_tick while IDLE -> no change.
2. Right wall: launch, xstep=5, ystep=0; after 63 ticks ball_x=635 -> next tick ball_x=636, dir[0]=1, bounce_count=1.
3. Top wall: launch, xstep=0, ystep=7; after 34 ticks ball_y=2 -> next tick ball_y=0, dir[1]=0, bounce_count=1.
4. Paddle hit: continuing test 3 with paddle_x=316; after 65 more ticks ball_y=455 -> next tick ball_y=456, dir[1]=1, bounce_count=2.
5. Miss: same as test 4 but paddle_x=0 -> ball_y=476, ball_lost high exactly one cycle, moving=0. Later ticks change nothing. launch -> ball_x=320, ball_y=240, dir=2'b10, moving=1, bounce_count=0.
6. Brick vs wall: from ball_x=635, dir[0]=0, xstep=5, tick with brick_hit_x=1 -> ball_x=630, dir[0]=1, bounce_count unchanged.

Source files
------------

// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the breakout control/timing logic and the ball motion engine.
// The master side drives controls and collision flags. The slave side returns ball state.
interface ball_motion_ctrl_if #(
  parameter int W      = 10,
  parameter int STEP_W = 4
);
  logic              launch;
  logic              frame_tick;
  logic [STEP_W-1:0] xstep;
  logic [STEP_W-1:0] ystep;
  logic [W-1:0]      paddle_x;
  logic              brick_hit_x;
  logic              brick_hit_y;
  logic [W-1:0]      ball_x;
  logic [W-1:0]      ball_y;
  logic [1:0]        dir;
  logic              moving;
  logic              ball_lost;
  logic [7:0]        bounce_count;

  modport master (
    output launch, frame_tick, xstep, ystep, paddle_x, brick_hit_x, brick_hit_y,
    input  ball_x, ball_y, dir, moving, ball_lost, bounce_count
  );

  modport slave (
    input  launch, frame_tick, xstep, ystep, paddle_x, brick_hit_x, brick_hit_y,
    output ball_x, ball_y, dir, moving, ball_lost, bounce_count
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Ball motion engine for breakout. On each frame tick in MOVE it steps the ball.
// It resolves brick toggles, wall bounces and the paddle hit or miss in one cycle.
module ball_motion_ctrl #(
  parameter int         W         = 10,
  parameter int         STEP_W    = 4,
  parameter int         X_MAX     = 639,
  parameter int         Y_MAX     = 479,
  parameter int         BALL_SIZE = 4,
  parameter int         PADDLE_Y  = 460,
  parameter int         PADDLE_W  = 32,
  parameter int         X_INIT    = 320,
  parameter int         Y_INIT    = 240,
  parameter logic [1:0] DIR_INIT  = 2'b10
) (
  input  logic                    clk,
  input  logic                    resetn,
  ball_motion_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, MOVE, LOST} state_t;

  // All collision arithmetic uses one extra bit. Candidates past the right edge
  // therefore do not wrap. Subtraction below zero is caught before its result is used.
  localparam logic [W:0]   SIZE_M1  = (W+1)'(BALL_SIZE - 1);
  localparam logic [W:0]   X_LIMIT  = (W+1)'(X_MAX);
  localparam logic [W:0]   X_WALL   = (W+1)'(X_MAX - BALL_SIZE + 1);
  localparam logic [W:0]   Y_PADDLE = (W+1)'(PADDLE_Y);
  localparam logic [W:0]   Y_REST   = (W+1)'(PADDLE_Y - BALL_SIZE);
  localparam logic [W:0]   Y_FLOOR  = (W+1)'(Y_MAX - BALL_SIZE + 1);
  localparam logic [W:0]   PAD_SPAN = (W+1)'(PADDLE_W - 1);
  localparam logic [W-1:0] X_START  = W'(X_INIT);
  localparam logic [W-1:0] Y_START  = W'(Y_INIT);

  state_t       state, next_state;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]   dir_q, dir_d;
  logic         lost_q, lost_d;
  logic [7:0]   count_q, count_d;

  logic [1:0]   eff_dir, new_dir;
  logic [W:0]   x_ext, y_ext, step_x, step_y, cand_x, cand_y, new_x, new_y, paddle_ext;
  logic         x_bounce, y_bounce, overlap, missed;
  logic [8:0]   count_sum;
  logic [7:0]   count_sat;

  // Resolve one motion step: brick toggles first, then X walls, then Y walls and paddle using the new X.
  always_comb begin
    eff_dir    = dir_q ^ {bus.brick_hit_y, bus.brick_hit_x};
    x_ext      = {1'b0, x_q};
    y_ext      = {1'b0, y_q};
    step_x     = (W+1)'(bus.xstep);
    step_y     = (W+1)'(bus.ystep);
    paddle_ext = {1'b0, bus.paddle_x};
    cand_x     = eff_dir[0] ? (x_ext - step_x) : (x_ext + step_x);
    cand_y     = eff_dir[1] ? (y_ext - step_y) : (y_ext + step_y);
    new_x      = cand_x;
    new_y      = cand_y;
    new_dir    = eff_dir;
    x_bounce   = 1'b0;
    y_bounce   = 1'b0;
    missed     = 1'b0;

    if (!eff_dir[0] && (cand_x + SIZE_M1 > X_LIMIT)) begin
      new_x      = X_WALL;
      new_dir[0] = 1'b1;
      x_bounce   = 1'b1;
    end else if (eff_dir[0] && (x_ext < step_x)) begin
      new_x      = '0;
      new_dir[0] = 1'b0;
      x_bounce   = 1'b1;
    end

    overlap = (new_x + SIZE_M1 >= paddle_ext) && (new_x <= paddle_ext + PAD_SPAN);

    if (eff_dir[1] && (y_ext < step_y)) begin
      new_y      = '0;
      new_dir[1] = 1'b0;
      y_bounce   = 1'b1;
    end else if (!eff_dir[1] && (cand_y + SIZE_M1 >= Y_PADDLE)) begin
      if (overlap) begin
        new_y      = Y_REST;
        new_dir[1] = 1'b1;
        y_bounce   = 1'b1;
      end else begin
        new_y  = Y_FLOOR;
        missed = 1'b1;
      end
    end

    count_sum = {1'b0, count_q} + 9'(x_bounce) + 9'(y_bounce);
    count_sat = count_sum[8] ? 8'hFF : count_sum[7:0];
  end

  // Next-state and register-load decisions. Nothing moves outside a MOVE tick.
  always_comb begin
    next_state = state;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    count_d    = count_q;
    lost_d     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.launch) begin
          next_state = MOVE;
          count_d    = '0;
        end
      end
      MOVE: begin
        if (bus.frame_tick) begin
          x_d     = new_x[W-1:0];
          y_d     = new_y[W-1:0];
          dir_d   = new_dir;
          count_d = count_sat;
          if (missed) begin
            next_state = LOST;
            lost_d     = 1'b1;
          end
        end
      end
      LOST: begin
        if (bus.launch) begin
          next_state = MOVE;
          x_d        = X_START;
          y_d        = Y_START;
          dir_d      = DIR_INIT;
          count_d    = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State and ball registers. Reset returns the ball to its launch point immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      x_q     <= X_START;
      y_q     <= Y_START;
      dir_q   <= DIR_INIT;
      lost_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state   <= next_state;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      lost_q  <= lost_d;
      count_q <= count_d;
    end
  end

  assign bus.ball_x       = x_q;
  assign bus.ball_y       = y_q;
  assign bus.dir          = dir_q;
  assign bus.moving       = (state == MOVE);
  assign bus.ball_lost    = lost_q;
  assign bus.bounce_count = count_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl.
// A behavioural model computes ball motion with signed integer arithmetic and is compared every cycle.
// Directed scenarios pin the model with hand-computed values, then randomized traffic follows.
module tb_ball_motion_ctrl;

  localparam int W      = 10;
  localparam int STEP_W = 4;
  localparam int XMAX   = 639;
  localparam int YMAX   = 479;
  localparam int SIZE   = 4;
  localparam int PAD_Y  = 460;
  localparam int PAD_W  = 32;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_LOST = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ball_motion_ctrl_if #(.W(W), .STEP_W(STEP_W)) bus ();

  ball_motion_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // model state
  int m_mode, m_x, m_y, m_cnt;
  bit m_left, m_up, m_lost;
  int t_x, t_y, t_xs, t_ys, t_px, t_hits;
  bit t_left, t_up;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: signed positions, clamp at walls, paddle overlap tested as interval intersection.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_IDLE; m_x = 320; m_y = 240; m_left = 0; m_up = 1; m_lost = 0; m_cnt = 0;
    end else begin
      m_lost = 0;
      if (m_mode == M_IDLE) begin
        if (bus.launch) begin m_mode = M_MOVE; m_cnt = 0; end
      end else if (m_mode == M_LOST) begin
        if (bus.launch) begin
          m_mode = M_MOVE; m_x = 320; m_y = 240; m_left = 0; m_up = 1; m_cnt = 0;
        end
      end else if (bus.frame_tick) begin
        t_left = m_left ^ bus.brick_hit_x;
        t_up   = m_up ^ bus.brick_hit_y;
        t_xs   = int'(bus.xstep);
        t_ys   = int'(bus.ystep);
        t_px   = int'(bus.paddle_x);
        t_hits = 0;
        t_x = t_left ? m_x - t_xs : m_x + t_xs;
        t_y = t_up   ? m_y - t_ys : m_y + t_ys;
        if (t_left && t_x < 0) begin
          t_x = 0; t_left = 0; t_hits++;
        end else if (!t_left && t_x + SIZE > XMAX + 1) begin
          t_x = XMAX + 1 - SIZE; t_left = 1; t_hits++;
        end
        if (t_up && t_y < 0) begin
          t_y = 0; t_up = 0; t_hits++;
        end else if (!t_up && t_y + SIZE > PAD_Y) begin
          if (t_x + SIZE > t_px && t_x < t_px + PAD_W) begin
            t_y = PAD_Y - SIZE; t_up = 1; t_hits++;
          end else begin
            t_y = YMAX + 1 - SIZE; m_mode = M_LOST; m_lost = 1;
          end
        end
        m_x = t_x; m_y = t_y; m_left = t_left; m_up = t_up;
        m_cnt = (m_cnt + t_hits > 255) ? 255 : m_cnt + t_hits;
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    check_output("ball_x", int'(bus.ball_x), m_x);
    check_output("ball_y", int'(bus.ball_y), m_y);
    check_output("dir", int'(bus.dir), int'({m_up, m_left}));
    check_output("moving", int'(bus.moving), (m_mode == M_MOVE) ? 1 : 0);
    check_output("ball_lost", int'(bus.ball_lost), int'(m_lost));
    check_output("bounce_count", int'(bus.bounce_count), m_cnt);
  end

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_launch();
    bus.launch = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic apply_stimulus();
    int r;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.frame_tick  = ($urandom_range(0, 1) == 1);
      bus.launch      = ($urandom_range(0, 15) == 0);
      bus.brick_hit_x = ($urandom_range(0, 15) == 0);
      bus.brick_hit_y = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.xstep = STEP_W'($urandom_range(0, 15));
        bus.ystep = STEP_W'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) begin
        r = m_x + 2 - int'($urandom_range(0, 36));
        if (r < 0) r = 0;
        bus.paddle_x = W'(r);
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 resetn = 1'b0;
        #4 resetn = 1'b1;
      end
    end
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.launch = 1'b0;
    bus.brick_hit_x = 1'b0; bus.brick_hit_y = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Directed scenarios, then randomized traffic
  initial begin
    bus.launch = 0; bus.frame_tick = 0; bus.xstep = 0; bus.ystep = 0;
    bus.paddle_x = 0; bus.brick_hit_x = 0; bus.brick_hit_y = 0;
    do_reset();
    check_output("rst_x", int'(bus.ball_x), 320);
    check_output("rst_dir", int'(bus.dir), 2);
    run_ticks(3);
    check_output("idle_y", int'(bus.ball_y), 240);
    check_output("idle_moving", int'(bus.moving), 0);

    $display("[TB] right wall");
    bus.xstep = 5; bus.ystep = 0;
    do_launch();
    check_output("launch_moving", int'(bus.moving), 1);
    run_ticks(63);
    check_output("rw_x_pre", int'(bus.ball_x), 635);
    run_ticks(1);
    check_output("rw_x", int'(bus.ball_x), 636);
    check_output("rw_dir", int'(bus.dir), 3);
    check_output("rw_cnt", int'(bus.bounce_count), 1);

    $display("[TB] reset mid-move");
    #2 resetn = 1'b0;
    #1;
    check_output("midrst_x", int'(bus.ball_x), 320);
    check_output("midrst_y", int'(bus.ball_y), 240);
    check_output("midrst_dir", int'(bus.dir), 2);
    check_output("midrst_moving", int'(bus.moving), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] brick vs wall");
    do_launch();
    run_ticks(63);
    bus.brick_hit_x = 1'b1;
    run_ticks(1);
    bus.brick_hit_x = 1'b0;
    check_output("brick_x", int'(bus.ball_x), 630);
    check_output("brick_dir0", int'(bus.dir[0]), 1);
    check_output("brick_cnt", int'(bus.bounce_count), 0);

    $display("[TB] top wall and paddle");
    do_reset();
    bus.xstep = 0; bus.ystep = 7; bus.paddle_x = 316;
    do_launch();
    run_ticks(34);
    check_output("tw_y_pre", int'(bus.ball_y), 2);
    run_ticks(1);
    check_output("tw_y", int'(bus.ball_y), 0);
    check_output("tw_dir1", int'(bus.dir[1]), 0);
    check_output("tw_cnt", int'(bus.bounce_count), 1);
    run_ticks(65);
    check_output("pd_y_pre", int'(bus.ball_y), 455);
    run_ticks(1);
    check_output("pd_y", int'(bus.ball_y), 456);
    check_output("pd_dir1", int'(bus.dir[1]), 1);
    check_output("pd_cnt", int'(bus.bounce_count), 2);

    $display("[TB] miss");
    do_reset();
    bus.paddle_x = 0;
    do_launch();
    run_ticks(100);
    run_ticks(1);
    check_output("miss_y", int'(bus.ball_y), 476);
    check_output("miss_lost", int'(bus.ball_lost), 1);
    check_output("miss_moving", int'(bus.moving), 0);
    @(negedge clk);
    check_output("miss_lost_end", int'(bus.ball_lost), 0);
    run_ticks(3);
    check_output("lost_frozen_y", int'(bus.ball_y), 476);
    do_launch();
    check_output("relaunch_x", int'(bus.ball_x), 320);
    check_output("relaunch_y", int'(bus.ball_y), 240);
    check_output("relaunch_dir", int'(bus.dir), 2);
    check_output("relaunch_moving", int'(bus.moving), 1);
    check_output("relaunch_cnt", int'(bus.bounce_count), 0);

    $display("[TB] randomized traffic");
    apply_stimulus();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
